tx_arbiter: RTL and testbench

Shares the terminal's single host-bound byte channel (UART transmitter input) between two requesters. The first is the PS/2 keyboard decoder, which emits single-byte key codes. The second is the response generator, which emits multi-byte packets such as the ESC / K identify reply. Response packets are never interleaved with keyboard bytes, and ties between the requesters alternate. The block sits between those two sources and the UART TX, all in the pixel clock domain.

---
 rtl/tx_arb_pkg.sv | 17 +
 rtl/byte_fifo.sv | 49 ++++
 rtl/tx_arbiter.sv | 133 +++++++++++++
 tb/tb_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the host-bound byte channel arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_KBD  = 2'd1,
    GRANT_RESP = 2'd2
  } tx_arb_state_t;

  typedef enum logic {
    KBD  = 1'b0,
    RESP = 1'b1
  } tx_src_t;

  localparam int TX_ARB_MAX_PKT = 8;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-2 byte FIFO, valid/ready on both sides; zero-latency read of head entry.
// Push refused while full (wr_rdy=0) even if a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_vld,
  input  logic [7:0] wr_dat,
  output logic       wr_rdy,
  output logic       rd_vld,
  output logic [7:0] rd_dat,
  input  logic       rd_rdy
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign push   = wr_vld && !full;
  assign pop    = rd_rdy && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates keyboard bytes and response packets onto the UART TX byte channel; accept->tx_valid 1 cycle.
// Packets are atomic, ties alternate, stalls follow tx_ready; TX_ARB_KBD_FIFO_EN adds a keyboard FIFO.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int MAX_PKT        = TX_ARB_MAX_PKT,
  parameter int KBD_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic [7:0] resp_data,
  input  logic       resp_valid,
  input  logic       resp_last,
  output logic       resp_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       overrun
);

  localparam int CW = $clog2(MAX_PKT);

  tx_arb_state_t state, state_nxt;
  tx_src_t       last_winner, winner_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          slot_free;
  logic          kbd_pend;
  logic [7:0]    kbd_byte;
  logic          kbd_acc;
  logic          resp_acc;
  logic          force_rel;

  assign slot_free  = !tx_valid || tx_ready;
  assign resp_ready = (state == GRANT_RESP) && slot_free;

`ifdef TX_ARB_KBD_FIFO_EN
  logic       fifo_vld;
  logic [7:0] fifo_dat;

  byte_fifo #(.DEPTH(KBD_FIFO_DEPTH)) u_kbd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (kbd_valid),
    .wr_dat  (kbd_data),
    .wr_rdy  (kbd_ready),
    .rd_vld  (fifo_vld),
    .rd_dat  (fifo_dat),
    .rd_rdy  (kbd_acc)
  );

  assign kbd_pend = fifo_vld;
  assign kbd_byte = fifo_dat;
`else
  localparam int unused_fifo_depth = KBD_FIFO_DEPTH;

  assign kbd_pend  = kbd_valid;
  assign kbd_byte  = kbd_data;
  assign kbd_ready = (state == GRANT_KBD) && slot_free;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = last_winner;
    count_nxt  = count;
    kbd_acc    = 1'b0;
    resp_acc   = 1'b0;
    force_rel  = 1'b0;
    case (state)
      IDLE: begin
        if (kbd_pend && resp_valid)
          state_nxt = (last_winner == KBD) ? GRANT_RESP : GRANT_KBD;
        else if (kbd_pend)
          state_nxt = GRANT_KBD;
        else if (resp_valid)
          state_nxt = GRANT_RESP;
      end
      GRANT_KBD: begin
        if (slot_free && kbd_pend) begin
          kbd_acc    = 1'b1;
          state_nxt  = IDLE;
          winner_nxt = KBD;
        end
      end
      GRANT_RESP: begin
        // Holds the grant even while the response source idles mid-packet.
        if (slot_free && resp_valid) begin
          resp_acc = 1'b1;
          if (resp_last || count == CW'(MAX_PKT - 1)) begin
            force_rel  = !resp_last;
            state_nxt  = IDLE;
            winner_nxt = RESP;
            count_nxt  = '0;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_winner <= RESP;
      count       <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      last_winner <= winner_nxt;
      count       <= count_nxt;
      overrun     <= force_rel;
      if (kbd_acc) begin
        tx_data  <= kbd_byte;
        tx_valid <= 1'b1;
      end else if (resp_acc) begin
        tx_data  <= resp_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: queue-driven sources, negedge monitor of the tx channel.
module tb_tx_arbiter;
  import tx_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_valid = 1'b0;
  logic       kbd_ready;
  logic [7:0] resp_data = 8'h00;
  logic       resp_valid = 1'b0;
  logic       resp_last = 1'b0;
  logic       resp_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;

  logic [7:0] log_q[$];
  int         log_cyc[$];
  logic [8:0] resp_q[$];
  logic [7:0] kbd_q[$];
  logic       resp_hs = 1'b0;
  logic       kbd_hs = 1'b0;

  always #5 clk = ~clk;

  tx_arbiter #(.MAX_PKT(8), .KBD_FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .kbd_data   (kbd_data),
    .kbd_valid  (kbd_valid),
    .kbd_ready  (kbd_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_last  (resp_last),
    .resp_ready (resp_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overrun    (overrun)
  );

  always @(posedge clk) cyc++;

  // Handshakes are sampled mid-cycle; they complete at the following posedge.
  always @(negedge clk) begin
    resp_hs = resp_valid && resp_ready;
    kbd_hs  = kbd_valid && kbd_ready;
    if (tx_valid && tx_ready) begin
      log_q.push_back(tx_data);
      log_cyc.push_back(cyc);
    end
    if (overrun) ovr_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (resp_hs && resp_q.size() > 0) void'(resp_q.pop_front());
    if (kbd_hs && kbd_q.size() > 0) void'(kbd_q.pop_front());
    if (resp_q.size() > 0) begin
      resp_valid = 1'b1;
      {resp_last, resp_data} = resp_q[0];
    end else begin
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      resp_data  = 8'h00;
    end
    if (kbd_q.size() > 0) begin
      kbd_valid = 1'b1;
      kbd_data  = kbd_q[0];
    end else begin
      kbd_valid = 1'b0;
      kbd_data  = 8'h00;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    resp_q.delete();
    kbd_q.delete();
    resp_hs  = 1'b0;
    kbd_hs   = 1'b0;
    tx_ready = 1'b1;
    cyc_wait(2);
    log_q.delete();
    log_cyc.delete();
    ovr_cnt = 0;
    reset_n = 1'b1;
    cyc_wait(1);
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      cyc_wait(1);
      k++;
    end
    checks++;
    if (log_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: tx bytes seen %0d, required %0d", name, log_q.size(), n);
    end
  endtask

  task automatic wait_resp_grant(input string name);
    int k = 0;
    while (dut.state != GRANT_RESP && k < 20) begin
      cyc_wait(1);
      k++;
    end
    checks++;
    if (dut.state !== GRANT_RESP) begin
      errors++;
      $display("FAIL %s_grant: state %0d, required %0d", name, dut.state, GRANT_RESP);
    end
  endtask

  task automatic test_reset();
    logic exp_kbd_rdy;
`ifdef TX_ARB_KBD_FIFO_EN
    exp_kbd_rdy = 1'b1;
`else
    exp_kbd_rdy = 1'b0;
`endif
    apply_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b, required 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %0b, required 0", resp_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b, required 0", overrun); end
    checks++; if (kbd_ready !== exp_kbd_rdy) begin errors++; $display("FAIL reset_kbd_ready: got %0b, required %0b", kbd_ready, exp_kbd_rdy); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d, required IDLE", dut.state); end
    checks++; if (dut.last_winner !== RESP) begin errors++; $display("FAIL reset_last_winner: got %0d, required RESP", dut.last_winner); end
  endtask

  task automatic test_kbd_only();
    apply_reset();
    kbd_q.push_back(8'h61);
    cyc_wait(10);
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL kbd_only_count: got %0d bytes, required 1", log_q.size()); end
    checks++; if (log_q[0] !== 8'h61) begin errors++; $display("FAIL kbd_only_data: got %h, required 61", log_q[0]); end
    checks++; if (dut.last_winner !== KBD) begin errors++; $display("FAIL kbd_only_winner: got %0d, required KBD", dut.last_winner); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL kbd_only_drain: tx_valid %0b, required 0", tx_valid); end
  endtask

  task automatic test_no_interleave();
    logic [7:0] exp[4] = '{8'h1B, 8'h2F, 8'h4B, 8'h41};
    apply_reset();
    resp_q.push_back({1'b0, 8'h1B});
    resp_q.push_back({1'b0, 8'h2F});
    resp_q.push_back({1'b1, 8'h4B});
    wait_resp_grant("interleave");
    kbd_q.push_back(8'h41);
    wait_log("interleave", 4, 30);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin errors++; $display("FAIL interleave_byte%0d: got %h, required %h", i, log_q[i], exp[i]); end
    end
    checks++;
    if (log_cyc[2] - log_cyc[0] != 2) begin errors++; $display("FAIL back_to_back: packet spans %0d cycles, required 2", log_cyc[2] - log_cyc[0]); end
  endtask

  task automatic test_tie();
    logic [7:0] exp[3] = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    kbd_q.push_back(8'h11);
    kbd_q.push_back(8'h33);
`ifdef TX_ARB_KBD_FIFO_EN
    cyc_wait(1);
`endif
    resp_q.push_back({1'b1, 8'h22});
    wait_log("tie", 3, 40);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin errors++; $display("FAIL tie_byte%0d: got %h, required %h", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp[11] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h5A, 8'h88, 8'h89};
    apply_reset();
    for (int i = 0; i < 10; i++) resp_q.push_back({1'b0, 8'h80 + 8'(i)});
    wait_resp_grant("overrun");
    kbd_q.push_back(8'h5A);
    wait_log("overrun", 11, 60);
    cyc_wait(3);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin errors++; $display("FAIL overrun_byte%0d: got %h, required %h", i, log_q[i], exp[i]); end
    end
    checks++;
    if (ovr_cnt != 1) begin errors++; $display("FAIL overrun_pulses: got %0d, required 1", ovr_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] exp[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int bad_dat = 0;
    int bad_rdy = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) resp_q.push_back({(i == 4), exp[i]});
    wait_log("stall", 2, 40);
    tx_ready = 1'b0;
    repeat (20) begin
      cyc_wait(1);
      if (tx_data !== 8'hA2 || tx_valid !== 1'b1) bad_dat++;
      if (resp_ready !== 1'b0) bad_rdy++;
    end
    checks++; if (bad_dat != 0) begin errors++; $display("FAIL stall_hold: %0d cycles not holding A2, required 0", bad_dat); end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL stall_resp_ready: %0d cycles high, required 0", bad_rdy); end
    tx_ready = 1'b1;
    wait_log("stall_resume", 5, 20);
    cyc_wait(5);
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL stall_count: got %0d bytes, required 5", log_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_q[i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d: got %h, required %h", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    apply_reset();
    tx_ready = 1'b0;
    resp_q.push_back({1'b0, 8'h51});
    resp_q.push_back({1'b0, 8'h52});
    while (tx_valid !== 1'b1 && k < 20) begin
      cyc_wait(1);
      k++;
    end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_load: tx_valid %0b, required 1", tx_valid); end
    kbd_q.push_back(8'h71);
    kbd_q.push_back(8'h72);
    kbd_q.push_back(8'h73);
    cyc_wait(6);
`ifdef TX_ARB_KBD_FIFO_EN
    checks++; if (dut.u_kbd_fifo.rd_vld !== 1'b1) begin errors++; $display("FAIL rstmid_fifo_fill: rd_vld %0b, required 1", dut.u_kbd_fifo.rd_vld); end
`endif
    reset_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: got %0b, required 0", tx_valid); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d, required IDLE", dut.state); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL rstmid_resp_ready: got %0b, required 0", resp_ready); end
`ifdef TX_ARB_KBD_FIFO_EN
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_kbd_ready: got %0b, required 1", kbd_ready); end
    checks++; if (dut.u_kbd_fifo.rd_vld !== 1'b0) begin errors++; $display("FAIL rstmid_fifo_empty: rd_vld %0b, required 0", dut.u_kbd_fifo.rd_vld); end
`else
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_kbd_ready: got %0b, required 0", kbd_ready); end
`endif
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_kbd_only();
    test_no_interleave();
    test_tie();
    test_overrun();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
